// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave: CPU register map, status/control bit
// positions and the frame FSM state type.
package spi_slave_pkg;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  localparam int ST_E    = 10;
  localparam int ST_RRDY = 9;
  localparam int ST_TRDY = 8;
  localparam int ST_TMT  = 7;
  localparam int ST_TOE  = 6;
  localparam int ST_ROE  = 5;
  localparam int ST_TUR  = 4;

  localparam int CT_IE    = 8;
  localparam int CT_IRRDY = 7;
  localparam int CT_ITRDY = 6;
  localparam int CT_ITOE  = 4;
  localparam int CT_IROE  = 3;
  localparam int CT_ITUR  = 2;

  // Only the interrupt-enable bits of the control register are storable.
  localparam logic [15:0] CTRL_MASK = 16'h01DC;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/spi_slave_if.sv
// CPU-side register bus of the SPI slave, with the CPU (master) and the
// peripheral (slave) views.
interface spi_slave_if;
  logic [2:0]  mem_addr;
  logic        spi_select;
  logic        read_n;
  logic        write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq;
  logic        dataavailable;
  logic        readyfordata;

  modport master (
    output mem_addr, spi_select, read_n, write_n, data_from_cpu,
    input  data_to_cpu, irq, dataavailable, readyfordata
  );

  modport slave (
    input  mem_addr, spi_select, read_n, write_n, data_from_cpu,
    output data_to_cpu, irq, dataavailable, readyfordata
  );
endinterface

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for one asynchronous pin plus an edge-detect flop.
// Edges are suppressed until the chain holds only post-reset samples.
module spi_slave_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic [STAGES:0]   vld_q, vld_d;

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = sync_q[STAGES-1];
    vld_d  = {vld_q[STAGES-1:0], 1'b1};
  end

  // NOTE: reset is synchronous, so it sits inside the clocked branch and the
  // sensitivity list names only clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      vld_q  <= vld_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = vld_q[STAGES] &  dout & ~prev_q;
  assign fall = vld_q[STAGES] & ~dout &  prev_q;

endmodule

// File: rtl/spi_slave_0.sv
// SPI slave (CPOL=0, CPHA=0) with a CPU register interface: rx/tx holding
// registers, status flags, interrupt enables and a registered irq.
module spi_slave_0
  import spi_slave_pkg::*;
#(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  spi_slave_if.slave  bus
);

  localparam int CW = $clog2(DATABITS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(SCLK), .dout(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .din(SS_n), .dout(ss_lvl), .rise(ss_rise), .fall(ss_fall));
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(MOSI), .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

  assign unused_sync = ^{sclk_lvl, ss_lvl, mosi_rise, mosi_fall};

  state_e              state_q, state_d;
  logic [DATABITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [DATABITS-1:0] rx_holding_q, rx_holding_d, tx_holding_q, tx_holding_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                byte_done_q, byte_done_d;
  logic                rrdy_q, rrdy_d, roe_q, roe_d, toe_q, toe_d, tur_q, tur_d;
  logic                tx_primed_q, tx_primed_d, rx_rd_q, rx_rd_d, irq_q, irq_d;
  logic [15:0]         ctrl_q, ctrl_d, data_to_cpu_q, data_to_cpu_d;

  logic        wr_en, rd_en, tx_wr, st_wr, ct_wr;
  logic        load_req, byte_cmpl, tx_accept, err;
  logic [15:0] status, rdata;

  assign wr_en = bus.spi_select & ~bus.write_n;
  assign rd_en = bus.spi_select & ~bus.read_n;
  assign tx_wr = wr_en & (bus.mem_addr == ADDR_TXDATA);
  assign st_wr = wr_en & (bus.mem_addr == ADDR_STATUS);
  assign ct_wr = wr_en & (bus.mem_addr == ADDR_CONTROL);

  // NOTE: every _d starts from its _q so no branch can leave a latch behind.
  always_comb begin
    state_d       = state_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_holding_d  = rx_holding_q;
    tx_holding_d  = tx_holding_q;
    cnt_d         = cnt_q;
    byte_done_d   = byte_done_q;
    rrdy_d        = rrdy_q;
    roe_d         = roe_q;
    toe_d         = toe_q;
    tur_d         = tur_q;
    tx_primed_d   = tx_primed_q;
    ctrl_d        = ctrl_q;
    data_to_cpu_d = data_to_cpu_q;
    rx_rd_d       = rd_en & (bus.mem_addr == ADDR_RXDATA);
    load_req      = 1'b0;
    byte_cmpl     = 1'b0;

    case (state_q)
      IDLE: if (ss_fall) begin
        state_d     = ACTIVE;
        cnt_d       = '0;
        byte_done_d = 1'b0;
        load_req    = 1'b1;
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d     = IDLE;
          cnt_d       = '0;
          byte_done_d = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[DATABITS-2:0], mosi_s};
            if (cnt_q == CW'(DATABITS - 1)) begin
              byte_cmpl   = 1'b1;
              cnt_d       = '0;
              byte_done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          // The falling edge after a finished byte fetches the next tx byte.
          if (sclk_fall) begin
            if (byte_done_q) begin
              load_req    = 1'b1;
              byte_done_d = 1'b0;
            end else begin
              tx_shift_d = tx_shift_q << 1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Clears are applied before the sets below so a same-cycle set wins.
    if (st_wr) begin
      rrdy_d = 1'b0;
      roe_d  = 1'b0;
      toe_d  = 1'b0;
      tur_d  = 1'b0;
    end
    if (rx_rd_q) rrdy_d = 1'b0;

    if (byte_cmpl) begin
      rx_holding_d = rx_shift_d;
      rrdy_d       = 1'b1;
      if (rrdy_q) roe_d = 1'b1;
    end

    if (load_req) begin
      if (tx_primed_q) begin
        tx_shift_d  = tx_holding_q;
        tx_primed_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        tur_d      = 1'b1;
      end
    end

    // A write racing a load is accepted: the load took the old byte.
    tx_accept = tx_wr & (~tx_primed_q | load_req);
    if (tx_accept) begin
      tx_holding_d = bus.data_from_cpu[DATABITS-1:0];
      tx_primed_d  = 1'b1;
    end else if (tx_wr) begin
      toe_d = 1'b1;
    end

    if (ct_wr) ctrl_d = bus.data_from_cpu & CTRL_MASK;

    err             = roe_q | toe_q | tur_q;
    status          = '0;
    status[ST_E]    = err;
    status[ST_RRDY] = rrdy_q;
    status[ST_TRDY] = ~tx_primed_q;
    status[ST_TMT]  = ~tx_primed_q & (state_q != ACTIVE);
    status[ST_TOE]  = toe_q;
    status[ST_ROE]  = roe_q;
    status[ST_TUR]  = tur_q;

    case (bus.mem_addr)
      ADDR_RXDATA:  rdata = 16'(rx_holding_q);
      ADDR_STATUS:  rdata = status;
      ADDR_CONTROL: rdata = ctrl_q;
      default:      rdata = '0;
    endcase
    if (rd_en) data_to_cpu_d = rdata;

    irq_d = (rrdy_q & ctrl_q[CT_IRRDY]) | (~tx_primed_q & ctrl_q[CT_ITRDY]) |
            (roe_q & ctrl_q[CT_IROE]) | (toe_q & ctrl_q[CT_ITOE]) |
            (tur_q & ctrl_q[CT_ITUR]) | (err & ctrl_q[CT_IE]);
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_holding_q  <= '0;
      tx_holding_q  <= '0;
      cnt_q         <= '0;
      byte_done_q   <= 1'b0;
      rrdy_q        <= 1'b0;
      roe_q         <= 1'b0;
      toe_q         <= 1'b0;
      tur_q         <= 1'b0;
      tx_primed_q   <= 1'b0;
      rx_rd_q       <= 1'b0;
      irq_q         <= 1'b0;
      ctrl_q        <= '0;
      data_to_cpu_q <= '0;
    end else begin
      state_q       <= state_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_holding_q  <= rx_holding_d;
      tx_holding_q  <= tx_holding_d;
      cnt_q         <= cnt_d;
      byte_done_q   <= byte_done_d;
      rrdy_q        <= rrdy_d;
      roe_q         <= roe_d;
      toe_q         <= toe_d;
      tur_q         <= tur_d;
      tx_primed_q   <= tx_primed_d;
      rx_rd_q       <= rx_rd_d;
      irq_q         <= irq_d;
      ctrl_q        <= ctrl_d;
      data_to_cpu_q <= data_to_cpu_d;
    end
  end

  assign MISO              = tx_shift_q[DATABITS-1];
  assign MISO_oe           = (state_q == ACTIVE);
  assign bus.data_to_cpu   = data_to_cpu_q;
  assign bus.irq           = irq_q;
  assign bus.dataavailable = rrdy_q;
  assign bus.readyfordata  = ~tx_primed_q;

endmodule

// File: tb/tb_spi_slave_0.sv
// Directed and randomized frames against a byte-level model of the SPI
// slave's holding registers, flags and interrupt enables.
module tb_spi_slave_0;

  logic clk = 1'b0;
  logic reset, SCLK, SS_n, MOSI;
  logic MISO, MISO_oe;

  spi_slave_if bus();

  spi_slave_0 #(.DATABITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: flags, holding bytes and the byte expected on MISO next.
  bit          m_rrdy, m_roe, m_toe, m_tur, m_primed, m_active;
  logic [7:0]  m_hold, m_rx, m_exp_tx;
  logic [15:0] m_ctrl;

  logic [15:0] rd;
  logic [7:0]  rv, unused_miso;
  int          nb;
  bit          pr;
  logic        irq_before;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_status();
    logic [15:0] s;
    s     = '0;
    s[10] = m_roe | m_toe | m_tur;
    s[9]  = m_rrdy;
    s[8]  = ~m_primed;
    s[7]  = ~m_primed & ~m_active;
    s[6]  = m_toe;
    s[5]  = m_roe;
    s[4]  = m_tur;
    return s;
  endfunction

  function automatic logic exp_irq();
    return (m_rrdy & m_ctrl[7]) | (~m_primed & m_ctrl[6]) | (m_roe & m_ctrl[3]) |
           (m_toe & m_ctrl[4]) | (m_tur & m_ctrl[2]) | ((m_roe | m_toe | m_tur) & m_ctrl[8]);
  endfunction

  task automatic model_reset();
    m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0; m_primed = 0; m_active = 0;
    m_hold = 8'h00; m_rx = 8'h00; m_exp_tx = 8'h00; m_ctrl = 16'h0000;
  endtask

  // Next transmitted byte: the primed tx byte, or zero with an underrun.
  task automatic model_load(output logic [7:0] v);
    if (m_primed) begin
      v = m_hold;
      m_primed = 0;
    end else begin
      v = 8'h00;
      m_tur = 1;
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    bus.mem_addr = a; bus.data_from_cpu = d; bus.spi_select = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.spi_select = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    bus.mem_addr = a; bus.spi_select = 1'b1; bus.read_n = 1'b0;
    @(negedge clk);
    bus.spi_select = 1'b0; bus.read_n = 1'b1;
    d = bus.data_to_cpu;
    @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] v);
    cpu_write(3'd1, {8'h00, v});
    if (!m_primed) begin
      m_hold = v;
      m_primed = 1;
    end else begin
      m_toe = 1;
    end
  endtask

  task automatic status_clear();
    cpu_write(3'd2, 16'h0000);
    m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0;
  endtask

  task automatic ctrl_write(input logic [15:0] v);
    cpu_write(3'd3, v);
    m_ctrl = v & 16'h01DC;
  endtask

  task automatic check_status(input string tag);
    logic [15:0] s;
    cpu_read(3'd2, s);
    check(tag, s, exp_status());
    check({tag, "_irq"}, {15'd0, bus.irq}, {15'd0, exp_irq()});
  endtask

  task automatic rx_check(input string tag);
    logic [15:0] d;
    cpu_read(3'd0, d);
    check(tag, d, {8'h00, m_rx});
    m_rrdy = 0;
    @(negedge clk);
  endtask

  task automatic spi_start();
    SS_n = 1'b0;
    m_active = 1;
    model_load(m_exp_tx);
    repeat (5) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (5) @(negedge clk);
    SS_n = 1'b1;
    m_active = 0;
    repeat (6) @(negedge clk);
  endtask

  // Clocks out the top nbits of mosi_b at clk/10; optionally writes the tx
  // register during the fourth SCLK-high phase.
  task automatic spi_bits(input logic [7:0] mosi_b, input int nbits, input bit prime,
                          input logic [7:0] pv, output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi_b[7-i];
      repeat (5) @(negedge clk);
      miso_b[7-i] = MISO;
      SCLK = 1'b1;
      if (prime && i == 3) begin
        tx_write(pv);
        repeat (4) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      SCLK = 1'b0;
    end
  endtask

  task automatic spi_byte(input string tag, input logic [7:0] mosi_b, input bit prime,
                          input logic [7:0] pv);
    logic [7:0] got;
    spi_bits(mosi_b, 8, prime, pv, got);
    check(tag, {8'h00, got}, {8'h00, m_exp_tx});
    if (m_rrdy) m_roe = 1;
    m_rrdy = 1;
    m_rx   = mosi_b;
    model_load(m_exp_tx);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    bus.mem_addr = 3'd0; bus.spi_select = 1'b0; bus.read_n = 1'b1;
    bus.write_n = 1'b1; bus.data_from_cpu = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_miso", {15'd0, MISO}, 16'd0);
    check("rst_oe", {15'd0, MISO_oe}, 16'd0);
    check("rst_irq", {15'd0, bus.irq}, 16'd0);
    check("rst_dout", bus.data_to_cpu, 16'h0000);
    check("rst_avail", {15'd0, bus.dataavailable}, 16'd0);
    check("rst_ready", {15'd0, bus.readyfordata}, 16'd1);
    check_status("rst_status");
    cpu_read(3'd3, rd);
    check("rst_ctrl", rd, 16'h0000);

    // Single byte: 0xA5 out, 0x3C in
    tx_write(8'hA5);
    check("a5_trdy", {15'd0, bus.readyfordata}, 16'd0);
    spi_start();
    check("a5_oe_on", {15'd0, MISO_oe}, 16'd1);
    spi_byte("a5_miso", 8'h3C, 1'b0, 8'h00);
    spi_end();
    check("a5_oe_off", {15'd0, MISO_oe}, 16'd0);
    check_status("a5_status");
    rx_check("a5_rx");
    check_status("a5_status_rd");

    // Two-byte frame, re-primed during the first byte
    status_clear();
    tx_write(8'hA5);
    spi_start();
    spi_byte("two_b0", 8'h01, 1'b1, 8'h5A);
    spi_byte("two_b1", 8'h02, 1'b0, 8'h00);
    spi_end();
    check_status("two_status");
    rx_check("two_rx");
    status_clear();
    check_status("two_cleared");

    // Underrun, then irq one cycle after enabling iTUR
    spi_start();
    spi_byte("tur_miso", 8'h77, 1'b0, 8'h00);
    spi_end();
    check_status("tur_status");
    irq_before = exp_irq();
    ctrl_write(16'hFE04);
    check("tur_irq_t1", {15'd0, bus.irq}, {15'd0, irq_before});
    @(negedge clk);
    check("tur_irq_t2", {15'd0, bus.irq}, {15'd0, exp_irq()});
    cpu_read(3'd3, rd);
    check("ctrl_rb", rd, m_ctrl);

    // Overrun of the tx register
    status_clear();
    tx_write(8'h11);
    tx_write(8'h22);
    check_status("toe_status");
    status_clear();
    check_status("toe_cleared");
    spi_start();
    spi_byte("toe_miso", 8'h99, 1'b0, 8'h00);
    spi_end();
    check_status("toe_after");

    // Frame aborted after 5 bits, then a full 0x81 frame
    spi_start();
    spi_bits(8'hC7, 5, 1'b0, 8'h00, unused_miso);
    spi_end();
    check("abort_oe", {15'd0, MISO_oe}, 16'd0);
    check_status("abort_status");
    spi_start();
    spi_byte("abort_next_miso", 8'h81, 1'b0, 8'h00);
    spi_end();
    rx_check("abort_next_rx");

    // Randomized frames
    for (int it = 0; it < 6; it++) begin
      status_clear();
      ctrl_write(16'($urandom));
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      nb = $urandom_range(1, 2);
      spi_start();
      for (int b = 0; b < nb; b++) begin
        pr = ($urandom_range(0, 1) == 1);
        rv = 8'($urandom);
        spi_byte($sformatf("rnd%0d_b%0d", it, b), rv, pr, 8'($urandom));
      end
      spi_end();
      check_status($sformatf("rnd%0d_status", it));
      rx_check($sformatf("rnd%0d_rx", it));
      check_status($sformatf("rnd%0d_status_rd", it));
    end

    // Reset mid-byte with SS_n held low
    tx_write(8'hE1);
    spi_start();
    spi_bits(8'h5B, 4, 1'b0, 8'h00, unused_miso);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("rstmid_oe", {15'd0, MISO_oe}, 16'd0);
    check("rstmid_miso", {15'd0, MISO}, 16'd0);
    check_status("rstmid_status");
    spi_bits(8'hFF, 8, 1'b0, 8'h00, unused_miso);
    check("rstmid_oe_clk", {15'd0, MISO_oe}, 16'd0);
    check_status("rstmid_ignored");
    SS_n = 1'b1;
    repeat (6) @(negedge clk);
    tx_write(8'hC3);
    spi_start();
    spi_byte("rstmid_recover_miso", 8'h42, 1'b0, 8'h00);
    spi_end();
    rx_check("rstmid_recover_rx");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
